// File: rtl/micro_tile_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : micro_tile_pkg
//  Description : Shared types and helpers for the micro-tile pin switch.
//                - tile_sw_state_t : handover sequencer states
//                - c_DATA_W_DEFAULT: default per-tile ui/uo bus width
//                - sel_width()     : select-code width for a tile count
//  Revision    : 1.0 - initial release
// ============================================================================
package micro_tile_pkg;

    typedef enum logic [1:0] {
        HOLD_NEW = 2'd0,
        RUN      = 2'd1,
        QUIESCE  = 2'd2
    } tile_sw_state_t;

    localparam int c_DATA_W_DEFAULT = 8;

    // At least one bit, even for the degenerate 2-tile case.
    function automatic int sel_width(input int n_tiles);
        return (n_tiles <= 2) ? 1 : $clog2(n_tiles);
    endfunction

endpackage
`default_nettype wire

// File: rtl/tile_clk_gate.sv
`default_nettype none
// ============================================================================
//  Module      : tile_clk_gate
//  Description : Latch-based integrated clock gate for one tile.
//  Ports       : clk_i - free-running clock
//                en_i  - clock enable (from a posedge register)
//                clk_o - gated clock
//  Revision    : 1.0 - initial release
// ============================================================================
module tile_clk_gate (
    input  logic clk_i,
    input  logic en_i,
    output logic clk_o
);

    logic en_q;

    // Enable only passes while clk is low, so a change can never chop the
    // high phase and produce a runt pulse.
    always_latch begin
        if (!clk_i) begin
            en_q = en_i;
        end
    end

    assign clk_o = clk_i & en_q;

endmodule
`default_nettype wire

// File: rtl/micro_tile_switch.sv
`default_nettype none
// ============================================================================
//  Module      : micro_tile_switch
//  Description : Time-shares one set of tile pins among N_TILES projects with
//                a sequenced handover: synchronise/debounce the request,
//                hold the outgoing tile in reset (clock running), then clock
//                the incoming tile through a held reset before routing it.
//  Ports       : clk, rst_n      - clock, async active-low reset
//                sel_req         - requested tile (asynchronous pins)
//                ui_in / uo_out  - pin-side data in / registered data out
//                tile_clk        - gated clock per tile
//                tile_rst_n      - active-low reset per tile
//                tile_ui/tile_uo - per-tile data, slice i = [i*DATA_W +: DATA_W]
//                active_sel      - tile currently owning the pins
//                busy            - high whenever not in RUN
//  Revision    : 1.0 - initial release
// ============================================================================
module micro_tile_switch
    import micro_tile_pkg::*;
#(
    parameter int N_TILES  = 4,
    parameter int SEL_W    = sel_width(N_TILES),
    parameter int DATA_W   = c_DATA_W_DEFAULT,
    parameter int RST_HOLD = 8,
    parameter int STABLE   = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [SEL_W-1:0]          sel_req,
    input  logic [DATA_W-1:0]         ui_in,
    output logic [N_TILES-1:0]        tile_clk,
    output logic [N_TILES-1:0]        tile_rst_n,
    output logic [N_TILES*DATA_W-1:0] tile_ui,
    input  logic [N_TILES*DATA_W-1:0] tile_uo,
    output logic [DATA_W-1:0]         uo_out,
    output logic [SEL_W-1:0]          active_sel,
    output logic                      busy
);

    localparam int CNT_W  = (RST_HOLD <= 2) ? 1 : $clog2(RST_HOLD);
    localparam int STAB_W = (STABLE <= 2) ? 1 : $clog2(STABLE);
    localparam logic [CNT_W-1:0]  c_CNT_LAST  = CNT_W'(RST_HOLD - 1);
    localparam logic [STAB_W-1:0] c_STAB_LAST = STAB_W'(STABLE - 1);
    localparam logic [SEL_W:0]    c_N_TILES   = (SEL_W + 1)'(N_TILES);

    logic [SEL_W-1:0]   sync1_q, s2_q;
    logic [STAB_W-1:0]  stab_q, stab_d;
    tile_sw_state_t     state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [SEL_W-1:0]   active_q, active_d;
    logic [SEL_W-1:0]   target_q, target_d;
    logic [N_TILES-1:0] clk_en_q, tile_rst_n_q, onehot_d, tile_rst_n_d;
    logic [DATA_W-1:0]  uo_q, uo_d, uo_sel;
    logic               busy_q, busy_d;
    logic               req_ok;

    // stab_q counts edges since s2 last changed, saturating at STABLE-1;
    // reaching the top means s2 has held for STABLE consecutive cycles.
    always_comb begin
        stab_d = stab_q;
        if (sync1_q != s2_q) begin
            stab_d = '0;
        end else if (stab_q != c_STAB_LAST) begin
            stab_d = stab_q + 1'b1;
        end
    end

    always_comb begin
        req_ok = (s2_q != active_q) && ({1'b0, s2_q} < c_N_TILES)
                 && (stab_q == c_STAB_LAST);
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q + 1'b1;
        active_d = active_q;
        target_d = target_q;
        unique case (state_q)
            HOLD_NEW: begin
                if (cnt_q == c_CNT_LAST) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end
            end
            RUN: begin
                cnt_d = '0;
                if (req_ok) begin
                    target_d = s2_q;
                    state_d  = QUIESCE;
                end
            end
            QUIESCE: begin
                if (cnt_q == c_CNT_LAST) begin
                    active_d = target_q;
                    state_d  = HOLD_NEW;
                    cnt_d    = '0;
                end
            end
            default: begin
                state_d = HOLD_NEW;
                cnt_d   = '0;
            end
        endcase
    end

    // The owned tile keeps its clock in every state: during QUIESCE so its
    // reset is actually clocked in, during HOLD_NEW so the new tile is.
    always_comb begin
        onehot_d = '0;
        uo_sel   = '0;
        for (int i = 0; i < N_TILES; i++) begin
            onehot_d[i] = (active_d == SEL_W'(i));
            if (active_q == SEL_W'(i)) begin
                uo_sel = tile_uo[i*DATA_W +: DATA_W];
            end
        end
        tile_rst_n_d = (state_d == RUN) ? onehot_d : '0;
        busy_d       = (state_d != RUN);
        // Only sample once the tile was already out of reset before this
        // edge; on the RUN-entry edge its output is still reset garbage.
        uo_d = ((state_q == RUN) && (state_d == RUN)) ? uo_sel : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q      <= '0;
            s2_q         <= '0;
            stab_q       <= '0;
            state_q      <= HOLD_NEW;
            cnt_q        <= '0;
            active_q     <= '0;
            target_q     <= '0;
            clk_en_q     <= '0;
            tile_rst_n_q <= '0;
            uo_q         <= '0;
            busy_q       <= 1'b1;
        end else begin
            sync1_q      <= sel_req;
            s2_q         <= sync1_q;
            stab_q       <= stab_d;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            active_q     <= active_d;
            target_q     <= target_d;
            clk_en_q     <= onehot_d;
            tile_rst_n_q <= tile_rst_n_d;
            uo_q         <= uo_d;
            busy_q       <= busy_d;
        end
    end

    generate
        for (genvar i = 0; i < N_TILES; i++) begin : g_tile
            tile_clk_gate u_gate (
                .clk_i (clk),
                .en_i  (clk_en_q[i]),
                .clk_o (tile_clk[i])
            );
            assign tile_ui[i*DATA_W +: DATA_W] =
                ((state_q == RUN) && (active_q == SEL_W'(i))) ? ui_in : '0;
        end
    endgenerate

    assign tile_rst_n = tile_rst_n_q;
    assign uo_out     = uo_q;
    assign active_sel = active_q;
    assign busy       = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_micro_tile_switch.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_micro_tile_switch
//  Description : Self-checking bench. Two instances (4 tiles and 3 tiles)
//                share stimulus; a timestamp-based reference model predicts
//                every output after every clock edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_micro_tile_switch;
    import micro_tile_pkg::*;

    localparam int R   = 8;
    localparam int STB = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [1:0]  sel_req = '0;
    logic [7:0]  ui_in = '0;
    logic [31:0] tile_uo = '0;

    logic [3:0]  tclk4, trst4;
    logic [31:0] tui4;
    logic [7:0]  uo4;
    logic [1:0]  act4;
    logic        busy4;
    logic [2:0]  tclk3, trst3;
    logic [23:0] tui3;
    logic [7:0]  uo3;
    logic [1:0]  act3;
    logic        busy3;

    always #5 clk = ~clk;

    micro_tile_switch #(.N_TILES(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .sel_req(sel_req), .ui_in(ui_in),
        .tile_clk(tclk4), .tile_rst_n(trst4), .tile_ui(tui4),
        .tile_uo(tile_uo), .uo_out(uo4), .active_sel(act4), .busy(busy4)
    );

    micro_tile_switch #(.N_TILES(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .sel_req(sel_req), .ui_in(ui_in),
        .tile_clk(tclk3), .tile_rst_n(trst3), .tile_ui(tui3),
        .tile_uo(tile_uo[23:0]), .uo_out(uo3), .active_sel(act3), .busy(busy3)
    );

    // Reference model: edges are numbered from reset release (first edge=1).
    // A switch accepted at edge a hands ownership over at a+R and the new
    // tile is running from edge a+2R on.
    int          n_checks = 0;
    int          n_pass   = 0;
    int          n_fail   = 0;
    int          k;
    int          hist[$];          // hist[i] = sel_req present at edge i+1
    int          run_start[2];
    int          sw_edge[2];
    int          target[2];
    int          active[2];
    logic [3:0]  prev_en[2];
    int          nt[2] = '{4, 3};
    bit          fix2 = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int s2_at(input int e);
        return (e >= 3) ? hist[e-3] : 0;
    endfunction

    task automatic model_reset();
        k = 0;
        hist.delete();
        for (int j = 0; j < 2; j++) begin
            run_start[j] = R;
            sw_edge[j]   = -1;
            target[j]    = 0;
            active[j]    = 0;
            prev_en[j]   = '0;
        end
    endtask

    task automatic model_check(input int j, input logic [31:0] tuo_b);
        int          s2;
        bit          stable, rb, ra, acc;
        logic [3:0]  oh, o_clk, o_rst;
        logic [31:0] exp_ui, o_ui;
        logic [7:0]  exp_uo, o_uo;
        logic [1:0]  o_act;
        logic        o_busy;
        string       sfx;
        sfx = $sformatf("[n%0d k%0d]", nt[j], k);
        rb = (run_start[j] <= k - 1);
        s2 = s2_at(k);
        stable = 1'b1;
        for (int m = 1; m < STB; m++) if (s2_at(k - m) != s2) stable = 1'b0;
        acc = rb && (s2 != active[j]) && (s2 < nt[j]) && stable;
        if (acc) begin
            sw_edge[j]   = k;
            target[j]    = s2;
            run_start[j] = k + 2 * R;
        end
        if (sw_edge[j] >= 0 && k >= sw_edge[j] + R) begin
            active[j]  = target[j];
            sw_edge[j] = -1;
        end
        ra = (run_start[j] <= k);
        oh = 4'b0001 << active[j];
        exp_uo = (rb && ra) ? tuo_b[active[j]*8 +: 8] : 8'h00;
        exp_ui = '0;
        if (ra) exp_ui[active[j]*8 +: 8] = ui_in;
        if (j == 0) begin
            o_clk = tclk4; o_rst = trst4; o_ui = tui4; o_uo = uo4; o_act = act4; o_busy = busy4;
        end else begin
            o_clk = {1'b0, tclk3}; o_rst = {1'b0, trst3}; o_ui = {8'h00, tui3};
            o_uo = uo3; o_act = act3; o_busy = busy3;
        end
        chk({"busy", sfx},       32'(o_busy), 32'(!ra));
        chk({"active_sel", sfx}, 32'(o_act),  32'(active[j]));
        chk({"tile_rst_n", sfx}, 32'(o_rst),  32'(ra ? oh : 4'b0000));
        chk({"uo_out", sfx},     32'(o_uo),   32'(exp_uo));
        chk({"tile_ui", sfx},    o_ui,        exp_ui);
        // At posedge+1 the gate latch still holds the enable from before this edge.
        chk({"tile_clk", sfx},   32'(o_clk),  32'(prev_en[j]));
        prev_en[j] = oh;
    endtask

    task automatic tick();
        logic [31:0] tuo_b;
        hist.push_back(int'(sel_req));
        tuo_b = tile_uo;
        @(posedge clk);
        #1;
        k++;
        for (int j = 0; j < 2; j++) model_check(j, tuo_b);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            tile_uo = $urandom;
            if (fix2) tile_uo[23:16] = 8'hA5;
            ui_in = 8'($urandom);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " busy4"}, 32'(busy4), 32'd1);
        chk({tag, " busy3"}, 32'(busy3), 32'd1);
        chk({tag, " act4"},  32'(act4),  32'd0);
        chk({tag, " act3"},  32'(act3),  32'd0);
        chk({tag, " rst4"},  32'(trst4), 32'd0);
        chk({tag, " rst3"},  32'(trst3), 32'd0);
        chk({tag, " uo4"},   32'(uo4),   32'd0);
        chk({tag, " uo3"},   32'(uo3),   32'd0);
        chk({tag, " ui4"},   tui4,       32'd0);
        chk({tag, " ui3"},   32'(tui3),  32'd0);
    endtask

    // Entered at posedge+1; releases reset at a later posedge+2.
    task automatic do_reset();
        #1 rst_n = 1'b0;
        #1 chk_reset_outputs("rst_async");
        @(negedge clk);
        #1;
        chk("rst_tclk4_low", 32'(tclk4), 32'd0);
        chk("rst_tclk3_low", 32'(tclk3), 32'd0);
        @(posedge clk);
        #1;
        chk("rst_tclk4_high", 32'(tclk4), 32'd0);
        chk_reset_outputs("rst_held");
        #1 rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        model_reset();
        @(posedge clk);
        #1;
        // Bring-up from reset with sel_req = 0.
        sel_req = 2'd0;
        do_reset();
        run(7);
        chk("bringup_rst_low",  32'(trst4), 32'h0);
        chk("bringup_busy_hi",  32'(busy4), 32'd1);
        run(1);
        chk("bringup_rst_up",   32'(trst4), 32'h1);
        chk("bringup_busy_lo",  32'(busy4), 32'd0);
        run(4);

        // Switch 0 -> 2 with tile 2 presenting 8'hA5.
        fix2 = 1'b1;
        tile_uo[23:16] = 8'hA5;
        sel_req = 2'd2;
        run(3);
        chk("sw02_not_yet", 32'(busy4), 32'd0);
        run(1);
        chk("sw02_quiesce", 32'(busy4), 32'd1);
        run(8);
        chk("sw02_active",  32'(act4),  32'd2);
        chk("sw02_hold_rst", 32'(trst4), 32'h0);
        run(8);
        chk("sw02_rst_n",   32'(trst4), 32'h4);
        run(1);
        chk("sw02_uo",      32'(uo4),   32'hA5);
        chk("sw02_uo3",     32'(uo3),   32'hA5);
        fix2 = 1'b0;

        // One-cycle glitch on sel_req is ignored.
        sel_req = 2'd1;
        run(1);
        sel_req = 2'd2;
        run(8);
        chk("glitch_busy",   32'(busy4), 32'd0);
        chk("glitch_active", 32'(act4),  32'd2);

        // Code 3 is out of range for the 3-tile instance only.
        sel_req = 2'd3;
        run(20);
        chk("oor_busy3",   32'(busy3), 32'd0);
        chk("oor_active3", 32'(act3),  32'd2);
        chk("oor_active4", 32'(act4),  32'd3);
        sel_req = 2'd1;
        run(30);
        chk("after_oor_act3", 32'(act3), 32'd1);
        chk("after_oor_act4", 32'(act4), 32'd1);

        // Request changes during QUIESCE: first switch completes, then the next.
        sel_req = 2'd0;
        run(6);
        sel_req = 2'd3;
        run(14);
        chk("midreq_run",   32'(busy4), 32'd0);
        chk("midreq_first", 32'(act4),  32'd0);
        run(1);
        chk("midreq_second", 32'(busy4), 32'd1);
        run(30);
        chk("midreq_act4", 32'(act4), 32'd3);
        chk("midreq_act3", 32'(act3), 32'd0);

        // Reset pulse in the middle of HOLD_NEW for tile 2.
        sel_req = 2'd2;
        run(15);
        chk("pre_rst_act", 32'(act4), 32'd2);
        do_reset();
        run(8);
        chk("post_rst_up",  32'(trst4), 32'h1);
        run(40);
        chk("post_rst_act4", 32'(act4), 32'd2);
        chk("post_rst_act3", 32'(act3), 32'd2);

        // Random request sequences with occasional glitches and resets.
        for (int it = 0; it < 40; it++) begin
            sel_req = 2'($urandom_range(0, 3));
            run($urandom_range(1, 25));
            if ($urandom_range(0, 14) == 0) do_reset();
        end
        run(40);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/micro_tile_switch.md
# micro_tile_switch

Parametrised container that time-shares one set of tile pins among `N_TILES` micro-tile projects, selected by an external code. It replaces free combinational select muxing with a sequenced handover: synchronise and debounce the request, quiesce and reset the outgoing tile, then clock the incoming tile through a held reset before routing its outputs. It sits between the top-level pins and the per-project tile instances.

## Interface

- `N_TILES`, 4: number of tiles, 2..16.
- `SEL_W`, `$clog2(N_TILES)`: select code width.
- `DATA_W`, 8: width of the ui/uo bus per tile.
- `RST_HOLD`, 8: cycles for quiesce and for new-tile reset, ≥2.
- `STABLE`, 2: consecutive synchronised cycles a request must hold, ≥1.

- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `sel_req`  in  SEL_W  requested tile, asynchronous pin input.
- `ui_in`  in  DATA_W  pin data toward the tiles.
- `tile_clk`  out  N_TILES  gated clock per tile.
- `tile_rst_n`  out  N_TILES  per-tile active-low reset.
- `tile_ui`  out  N_TILES*DATA_W  per-tile input, slice i = bits [i*DATA_W +: DATA_W].
- `tile_uo`  in  N_TILES*DATA_W  per-tile output, same slicing.
- `uo_out`  out  DATA_W  registered output of the active tile.
- `active_sel`  out  SEL_W  tile currently owned.
- `busy`  out  1  high whenever state ≠ RUN.

## Operation

- `sel_req` passes through a 2-flop synchroniser (`s2`). A stability counter tracks `s2`. A request is accepted only in RUN, and only when all of these hold: `s2` ≠ `active_sel`, `s2` < `N_TILES`, and `s2` unchanged for `STABLE` consecutive cycles. Out-of-range codes are ignored and the current tile stays active.
- States:
  - HOLD_NEW: `tile_clk` enabled for `active_sel` only. Its `tile_rst_n` is 0. Lasts `RST_HOLD` cycles, then goes to RUN.
  - RUN: active tile has its clock, `tile_rst_n`=1, and `tile_ui`=`ui_in`. On an accepted request, the target is latched and the state goes to QUIESCE.
  - QUIESCE: old tile's `tile_rst_n` is 0, its clock stays enabled, and its `tile_ui` is 0. Lasts `RST_HOLD` cycles. Then `active_sel` ← target and the state goes to HOLD_NEW.
- Non-active tiles always have: clock disabled, `tile_rst_n`=0, `tile_ui`=0.
- `uo_out` = `tile_uo[active_sel]` registered in RUN, and 0 in every other state.
- Counter `cnt` runs 0..`RST_HOLD`-1. It clears on every state entry. The state transitions when `cnt` = `RST_HOLD`-1.
- Requests arriving during QUIESCE or HOLD_NEW do not alter the latched target. They are re-evaluated once RUN is reached, provided they are still stable.

## Timing

- While `rst_n`=0:
  - `state`=HOLD_NEW, `cnt`=0, `active_sel`=0, target=0.
  - Synchroniser and stability counter cleared.
  - All clock enables 0, `tile_rst_n`=0, `tile_ui`=0, `uo_out`=0, `busy`=1.
- After reset release:
  - Tile 0 clock enable registers high on the first edge.
  - `tile_rst_n[0]` rises `RST_HOLD` edges after release, and `busy` falls on the same edge.
- Request latency, from a stable `sel_req` change to the QUIESCE entry edge: 2 (sync) + `STABLE` cycles.
- Full switch: QUIESCE `RST_HOLD` + HOLD_NEW `RST_HOLD` cycles.
- `uo_out` lags `tile_uo` by 1 cycle in RUN. It is forced to 0 on the edge that leaves RUN.
- Clock enables change only through the latch-based gate: no glitch or runt pulse on `tile_clk`.
- Reset asserted mid-operation: everything returns immediately to its reset values. Any latched target is discarded.
- `STABLE`=1 with a `sel_req` toggle every cycle: no request is accepted unless `s2` held for one full cycle.

## Structure

- Package `micro_tile_pkg`:
  - state enum `tile_sw_state_t` (HOLD_NEW, RUN, QUIESCE);
  - the `DATA_W` default;
  - a function computing `SEL_W`.
- Sub-module `tile_clk_gate`: latch-based ICG (enable latched while `clk` low, AND with `clk`). One instance per tile.
- Synchroniser inline; everything else is in the top FSM.

## Test plan

All scenarios use defaults unless a parameter is stated.

- **Reset release, `sel_req`=0:** `tile_rst_n` = 4'b0000 for 8 cycles, then 4'b0001. `busy` 1→0 on the same edge. `uo_out` tracks `tile_uo[0]` one cycle later.
- **Switch 0→2, `tile_uo[2]`=8'hA5:** QUIESCE entered 4 cycles after `sel_req` changes. Tile 0 reset for 8 cycles with clock running. `active_sel`=2, then 8 cycles of tile 2 reset. Then `tile_rst_n`=4'b0100 and `uo_out`=8'hA5. `uo_out`=0 throughout the switch.
- **Glitch on `sel_req`** (0→1 for 1 cycle, then back): no state change, `busy` stays 0, `active_sel`=0.
- **`N_TILES`=3, `sel_req`=3 held 20 cycles:** ignored, `active_sel` unchanged, `busy`=0. Then `sel_req`=1 → normal switch to tile 1.
- **Request during switch:** `sel_req` changes 0→1 and then to 3 during QUIESCE. Tile 1 is completed first, then a second switch to tile 3 starts on entering RUN.
- **`rst_n` pulsed low mid-HOLD_NEW of tile 2:** all outputs return to reset values immediately, `active_sel`=0. After release, tile 0 is brought up per the first scenario, then a switch to 2 is issued because `sel_req` still reads 2.
